// File: rtl/neuron_mac_if.sv
// Bus bundle for one neuron MAC: weight-memory write port, bias load,
// the input sample stream and the summed result.
interface neuron_mac_if #(
    parameter int dataWidth    = 16,
    parameter int addressWidth = 10
);
    logic                      weightValid;
    logic [addressWidth-1:0]   weightAddr;
    logic [dataWidth-1:0]      weightIn;
    logic                      biasValid;
    logic [2*dataWidth-1:0]    biasIn;
    logic [dataWidth-1:0]      myinput;
    logic                      myinputValid;
    logic [2*dataWidth-1:0]    sum;
    logic                      sumValid;

    // Producer side: loads weights/bias, streams inputs, consumes sums
    modport master (
        output weightValid, weightAddr, weightIn,
        output biasValid, biasIn,
        output myinput, myinputValid,
        input  sum, sumValid
    );

    // The MAC itself
    modport slave (
        input  weightValid, weightAddr, weightIn,
        input  biasValid, biasIn,
        input  myinput, myinputValid,
        output sum, sumValid
    );
endinterface

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate stage. Streams numWeight signed inputs,
// multiplies each by its stored weight, accumulates with signed saturation,
// then adds the bias and emits a full-width sum with a one-cycle valid pulse.
module neuron_mac #(
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    neuron_mac_if.slave bus
);
    localparam int PW = 2 * dataWidth;
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);
    localparam logic [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

    // Two's complement add that clamps instead of wrapping: overflow can only
    // happen when both operands share a sign and the result flips it.
    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
        logic [PW-1:0] s;
        s = a + b;
        if (!a[PW-1] && !b[PW-1] && s[PW-1])
            s = SAT_MAX;
        else if (a[PW-1] && b[PW-1] && !s[PW-1])
            s = SAT_MIN;
        return s;
    endfunction

    // Weight storage: not reset, so weights survive a mid-vector reset
    logic [dataWidth-1:0] wmem [numWeight];
    logic [dataWidth-1:0] weight_q;

    // Stage 1: read address counter, registered sample, valid and last flags
    logic [addressWidth-1:0] rAddr_q, rAddr_d;
    logic [dataWidth-1:0]    in_q;
    logic                    v_q;
    logic                    last1_q;

    // Stage 2: full-width product and its flags
    logic [PW-1:0] in_ext, w_ext;
    logic [PW-1:0] mul_q, mul_d;
    logic          mul_valid_q;
    logic          last2_q;

    // Stage 3 / bias cycle state
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] bias_q, bias_d;
    logic [PW-1:0] sum_q, sum_d;
    logic          bias_pend_q, bias_pend_d;
    logic          sum_valid_q, sum_valid_d;

    // Weight write port and 1-cycle synchronous read; a same-address
    // read/write returns the old word because both use the pre-edge array.
    always_ff @(posedge clk) begin
        if (bus.weightValid && (bus.weightAddr <= LAST_ADDR))
            wmem[bus.weightAddr] <= bus.weightIn;
        weight_q <= wmem[rAddr_q];
    end

    // Sign-extend both factors so the low PW bits of the product are exact
    assign in_ext = {{dataWidth{in_q[dataWidth-1]}}, in_q};
    assign w_ext  = {{dataWidth{weight_q[dataWidth-1]}}, weight_q};

    // Next-state logic for the counter, product, accumulator, bias and result
    always_comb begin
        rAddr_d     = rAddr_q;
        mul_d       = in_ext * w_ext;
        acc_d       = acc_q;
        bias_d      = bias_q;
        sum_d       = sum_q;
        bias_pend_d = bias_pend_q;
        sum_valid_d = 1'b0;

        if (bus.myinputValid)
            rAddr_d = (rAddr_q == LAST_ADDR) ? '0 : rAddr_q + 1'b1;

        if (bus.biasValid)
            bias_d = bus.biasIn;

        if (bias_pend_q) begin
            // Finish the vector; a product already arriving belongs to the
            // next vector, so it seeds the accumulator rather than being lost.
            sum_d       = sat_add(acc_q, bias_q);
            sum_valid_d = 1'b1;
            acc_d       = mul_valid_q ? mul_q : '0;
            bias_pend_d = mul_valid_q && last2_q;
        end else if (mul_valid_q) begin
            acc_d       = sat_add(acc_q, mul_q);
            bias_pend_d = last2_q;
        end
    end

    // Pipeline and control registers, all cleared by the async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rAddr_q     <= '0;
            in_q        <= '0;
            v_q         <= 1'b0;
            last1_q     <= 1'b0;
            mul_q       <= '0;
            mul_valid_q <= 1'b0;
            last2_q     <= 1'b0;
            acc_q       <= '0;
            bias_q      <= '0;
            sum_q       <= '0;
            bias_pend_q <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            rAddr_q     <= rAddr_d;
            in_q        <= bus.myinput;
            v_q         <= bus.myinputValid;
            last1_q     <= bus.myinputValid && (rAddr_q == LAST_ADDR);
            mul_q       <= mul_d;
            mul_valid_q <= v_q;
            last2_q     <= v_q && last1_q;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            sum_q       <= sum_d;
            bias_pend_q <= bias_pend_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.sum      = sum_q;
    assign bus.sumValid = sum_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with numWeight=4, dataWidth=16.
// A plain-arithmetic model predicts each vector's sum and the cycle its
// pulse must appear; a negedge process checks sum/sumValid every cycle.
module tb_neuron_mac;
    localparam int DW = 16;
    localparam int NW = 4;
    localparam int AW = 2;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    neuron_mac_if #(.dataWidth(DW), .addressWidth(AW)) bus ();

    neuron_mac #(.dataWidth(DW), .numWeight(NW), .addressWidth(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;

    exp_t        expq[$];
    longint      mw[NW];
    longint      mbias = 0;
    longint      macc  = 0;
    int          mcnt  = 0;
    logic [31:0] hold  = '0;

    function automatic longint s16(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint s32(input logic [31:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle output check
    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].at == cyc) begin
            chk("sumValid_pulse", 64'(bus.sumValid), 64'd1);
            chk("sum_value", 64'(bus.sum), 64'(expq[0].val));
            hold = expq[0].val;
            void'(expq.pop_front());
        end else begin
            chk("sumValid_idle", 64'(bus.sumValid), 64'd0);
            chk("sum_hold", 64'(bus.sum), 64'(hold));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input logic [15:0] x);
        bus.myinputValid = v;
        bus.myinput      = x;
        if (v) begin
            macc = clamp(macc + s16(x) * mw[mcnt]);
            mcnt++;
            if (mcnt == NW) begin
                exp_t e;
                e.val = 32'(clamp(macc + mbias));
                e.at  = cyc + 4;
                expq.push_back(e);
                macc = 0;
                mcnt = 0;
            end
        end
        tick();
        bus.myinputValid = 1'b0;
    endtask

    task automatic wr_weight(input int a, input logic [15:0] d);
        bus.weightValid = 1'b1;
        bus.weightAddr  = AW'(a);
        bus.weightIn    = d;
        mw[a]           = s16(d);
        tick();
        bus.weightValid = 1'b0;
    endtask

    task automatic load_bias(input logic [31:0] b);
        bus.biasValid = 1'b1;
        bus.biasIn    = b;
        tick();
        bus.biasValid = 1'b0;
        mbias         = s32(b);
    endtask

    task automatic drain();
        repeat (6) step(1'b0, 16'h0);
    endtask

    task automatic vec4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        step(1'b1, a);
        step(1'b1, b);
        step(1'b1, c);
        step(1'b1, d);
    endtask

    task automatic weights4(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        wr_weight(0, a);
        wr_weight(1, b);
        wr_weight(2, c);
        wr_weight(3, d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        expq.delete();
        macc  = 0;
        mcnt  = 0;
        mbias = 0;
        hold  = '0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rnd16(input bit big);
        logic [31:0] r;
        r = $urandom;
        if (big) return r[15:0];
        return 16'($signed(r[4:0]));
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bus.weightValid  = 1'b0;
        bus.weightAddr   = '0;
        bus.weightIn     = '0;
        bus.biasValid    = 1'b0;
        bus.biasIn       = '0;
        bus.myinput      = '0;
        bus.myinputValid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic sum
        weights4(16'd1, 16'd2, 16'd3, 16'd4);
        load_bias(32'd10);
        vec4(16'd1, 16'd1, 16'd1, 16'd1);
        chk("pin_basic", 64'(expq[$].val), 64'd20);
        drain();

        // Signed products
        weights4(-16'sd2, 16'sd3, -16'sd4, 16'sd5);
        load_bias(-32'sd5);
        vec4(16'sd7, -16'sd1, 16'sd2, -16'sd3);
        chk("pin_signed", 64'(expq[$].val), 64'hFFFF_FFD3);
        drain();

        // Gapped vector A, then back-to-back vector B
        weights4(16'd1, 16'd2, 16'd3, 16'd4);
        load_bias(32'd10);
        for (int i = 0; i < NW; i++) begin
            step(1'b1, 16'd1);
            if (i != NW - 1) repeat ($urandom_range(0, 3)) step(1'b0, 16'h0);
        end
        chk("pin_gapA", 64'(expq[$].val), 64'd20);
        vec4(16'd2, 16'd2, 16'd2, 16'd2);
        chk("pin_b2bB", 64'(expq[$].val), 64'd30);
        drain();

        // Bias loaded during the bias cycle must not affect that sum
        vec4(16'd1, 16'd1, 16'd1, 16'd1);
        step(1'b0, 16'h0);
        step(1'b0, 16'h0);
        load_bias(32'd99);
        chk("pin_oldbias", 64'(expq[$].val), 64'd20);
        drain();
        vec4(16'd1, 16'd1, 16'd1, 16'd1);
        chk("pin_newbias", 64'(expq[$].val), 64'd109);
        drain();

        // Positive saturation
        weights4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        load_bias(32'h7FFF_FFFF);
        vec4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk("pin_satpos", 64'(expq[$].val), 64'h7FFF_FFFF);
        drain();

        // Negative saturation
        weights4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        load_bias(32'h8000_0000);
        vec4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk("pin_satneg", 64'(expq[$].val), 64'h8000_0000);
        drain();

        // Reset mid-vector: partial vector and bias discarded, weights kept
        weights4(16'd1, 16'd2, 16'd3, 16'd4);
        load_bias(32'd10);
        step(1'b1, 16'd1);
        step(1'b1, 16'd1);
        do_reset();
        drain();
        vec4(16'd1, 16'd1, 16'd1, 16'd1);
        chk("pin_bias_reset", 64'(expq[$].val), 64'd10);
        drain();
        load_bias(32'd10);
        vec4(16'd1, 16'd1, 16'd1, 16'd1);
        chk("pin_after_reset", 64'(expq[$].val), 64'd20);
        drain();

        // Counter wrap: three back-to-back vectors
        for (int v = 0; v < 3; v++)
            for (int i = 0; i < NW; i++) step(1'b1, rnd16(1'b0));
        drain();

        // Randomised vectors: random weights, bias, gaps and magnitudes
        for (int n = 0; n < 30; n++) begin
            bit big;
            big = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) begin
                drain();
                for (int a = 0; a < NW; a++) wr_weight(a, rnd16(big));
                load_bias($urandom);
            end
            for (int i = 0; i < NW; i++) begin
                step(1'b1, rnd16(big));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step(1'b0, 16'h0);
            end
        end
        drain();
        drain();
        chk("all_sums_seen", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before 500000");
        $fatal(1);
    end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Per-neuron multiply-accumulate stage that feeds the activation stage (ReLU) of a fully connected layer. It streams `numWeight` signed inputs, multiplies each by a weight from a local writable weight memory, and accumulates the products with signed saturation. When a vector completes, it adds a bias and emits one full-width `2*dataWidth` sum with a single-cycle valid pulse, ready for the activation stage to truncate and clamp.

## Interface
Parameters:
- `dataWidth`, default 16: input and weight width (signed, two's complement).
- `numWeight`, default 784: inputs per vector, equal to the weight memory depth.
- `addressWidth`, default 10: weight address width; must satisfy 2^addressWidth >= numWeight.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `weightValid`, in, 1: weight memory write enable.
- `weightAddr`, in, addressWidth: weight write address.
- `weightIn`, in, dataWidth: weight write data.
- `biasValid`, in, 1: loads `biasIn` into the bias register.
- `biasIn`, in, 2*dataWidth: signed bias, in the same fixed-point format as the products.
- `myinput`, in, dataWidth: signed input sample.
- `myinputValid`, in, 1: `myinput` is valid this cycle. No backpressure; every valid cycle is consumed.
- `sum`, out, 2*dataWidth: saturated sum of products plus bias.
- `sumValid`, out, 1: one-cycle pulse marking `sum` as new.

## Operation
- **Weight memory**: `numWeight` x `dataWidth`, synchronous write and synchronous read (1-cycle read latency). It is not cleared by reset. If a read and a write hit the same address in the same cycle, the read returns the old data. Writes are allowed only while no vector is in flight; writing during a vector gives an undefined sum.
- **Bias register**: loaded on `biasValid`; resets to 0.
- **Input counter `rAddr`**: drives the read address. It increments on each `myinputValid` and wraps to 0 after `numWeight-1`.
- **Stage 1 (input cycle t)**:
  - Read weight[`rAddr`].
  - Register `myinput` and the valid flag into `in_d`/`v_d`.
  - Also register a `last` flag when `rAddr == numWeight-1`.
- **Stage 2 (cycle t+1)**:
  - `mul <= $signed(in_d) * $signed(weight)`, full 2*dataWidth width, no truncation.
  - `mul_valid <= v_d`; `last` is carried along.
- **Stage 3 (cycle t+2)**: if `mul_valid`, `acc <= sat(acc + mul)`. If the product was flagged `last`, set `biasPending`.
- **Bias cycle (the cycle after `biasPending` is set)**:
  - `sum <= sat(acc + bias)` and `sumValid <= 1`.
  - `acc <= mul_valid ? mul : 0`. This lets a back-to-back next vector start without losing its first product.
  - `biasPending <= 0`.
- **`sat(a+b)`**:
  - Both operands non-negative and result negative: force `{1'b0,{(2*dataWidth-1){1'b1}}}`.
  - Both operands negative and result non-negative: force `{1'b1,{(2*dataWidth-1){1'b0}}}`.
  - Otherwise: the wrapped sum.
- **Reset** (`rst_n` low, at any time, including mid-vector): `rAddr`, `acc`, `bias`, `sum`, `sumValid`, all pipeline valid/last flags and `biasPending` go to 0 immediately. The partial vector is discarded.

## Timing
- Reset values: `sum` = 0, `sumValid` = 0.
- Pipeline: input accept -> product registered 2 edges later -> accumulated 3 edges later.
- Latency: the last input of a vector, accepted at cycle T, produces `sumValid` high during cycle T+4, for exactly one cycle.
- `sum` holds its value until the next bias cycle.
- Inputs may be gapped arbitrarily. Gaps stall nothing and add no extra latency beyond the gap itself.
- Back-to-back vectors (next vector's first input at T+1) are fully supported, giving one sum per `numWeight` valid cycles.
- `biasValid` takes effect on the next edge. A bias loaded in the same cycle as the bias cycle is not used for that sum (the old bias is used).
- `weightValid` takes effect on the next edge.

## Test plan
Use `numWeight` = 4, `dataWidth` = 16 unless noted.
- **Basic sum**: weights 1,2,3,4 (raw integers), bias 10, inputs 1,1,1,1 contiguous -> `sum` = 20, `sumValid` one cycle at T+4.
- **Signed products**: weights -2,3,-4,5, inputs 7,-1,2,-3, bias -5 -> `sum` = -14-3-8-15-5 = -45.
- **Gapped then back-to-back**:
  - Insert random idle cycles between the inputs of vector A (same data as the basic test) -> `sum` = 20.
  - Follow immediately with vector B, inputs 2,2,2,2 -> second pulse with `sum` = 30, exactly 4 cycles after B's last input.
- **Saturation**:
  - Weights and inputs all 0x7FFF, bias 0x7FFFFFFF -> `sum` = 0x7FFFFFFF.
  - Weights 0x8000, inputs 0x7FFF, bias 0x80000000 -> `sum` = 0x80000000.
- **Reset mid-vector**:
  - Pulse `rst_n` low after 2 inputs -> `sumValid` = 0, `sum` = 0, bias = 0.
  - Reload the bias as 10, then send a full vector with the basic-test data -> `sum` = 20, confirming the weights survived reset.
- **Counter wrap**: 3 consecutive vectors, each with 4 inputs -> 3 pulses, each sum correct; `rAddr` wraps 3 -> 0 each time.
